spi_ram_burst_ctrl: RTL and testbench
=====================================

Name: spi_ram_burst_ctrl

Overview:
- Parametrised command-decoding RAM that sits behind the SPI slave, which delivers (DATA_W+2)-bit frames on din/rx_valid.
- Generalises the single-port SPI RAM in four ways:
  - configurable data width, address width and depth;
  - multi-frame address capture when ADDR_W > DATA_W;
  - independent read and write pointers with burst auto-increment;
  - tx_valid/tx_ready backpressure with overrun and address-error reporting.

Parameters:
- DATA_W, 8: word width; also the payload width of din.
- ADDR_W, 10: address pointer width; must satisfy 2**ADDR_W >= MEM_DEPTH.
- MEM_DEPTH, 1024: number of words. Need not be a power of 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- rx_valid  in  1  din holds a valid frame this cycle.
- din  in  DATA_W+2  command frame: opcode = din[DATA_W+1:DATA_W], payload = din[DATA_W-1:0].
- tx_ready  in  1  downstream (SPI slave) accepts dout this cycle.
- dout  out  DATA_W  read data.
- tx_valid  out  1  dout valid; held until accepted.
- rd_overrun  out  1  one-cycle pulse: READ dropped because a word was pending.
- addr_err  out  1  sticky: an access hit an address >= MEM_DEPTH.

Behaviour:
- Reset (rst_n=0 at posedge) clears wr_ptr, rd_ptr, dout, tx_valid, rd_overrun and addr_err to 0. Memory contents are not cleared. Reset mid-burst abandons the burst; a pending tx word is discarded.
- Opcodes (decoded only when rx_valid=1):
  - 0 WR_ADDR: wr_ptr <= ((wr_ptr << DATA_W) | payload), truncated to ADDR_W bits. ceil(ADDR_W/DATA_W) consecutive WR_ADDR frames, MSB-first, load a full address. Frames beyond that count keep shifting; the oldest bits fall off.
  - 1 WRITE: mem[wr_ptr] <= payload, then wr_ptr advances.
  - 2 RD_ADDR: same shift-load as WR_ADDR, applied to rd_ptr.
  - 3 READ:
    - Accepted if tx_valid=0, or tx_valid=1 and tx_ready=1 in the same cycle.
    - On accept: dout <= mem[rd_ptr] and tx_valid <= 1 at the same edge (zero extra latency), then rd_ptr advances.
    - Not accepted: no state change except rd_overrun=1 for exactly one cycle.
- Pointer advance: ptr <= (ptr == MEM_DEPTH-1) ? 0 : ptr+1. Wrap is at MEM_DEPTH, not at 2**ADDR_W.
- Out-of-range pointer (ptr >= MEM_DEPTH, possible when MEM_DEPTH is not a power of 2):
  - WRITE: memory is unchanged, addr_err <= 1, ptr <= 0.
  - READ (accepted): dout <= 0, tx_valid <= 1, addr_err <= 1, rd_ptr <= 0.
- tx handshake:
  - tx_valid falls at the edge where tx_ready=1 and no READ is accepted.
  - tx_ready=1 with tx_valid=0 has no effect.
  - dout is stable while tx_valid=1 and tx_ready=0.
- Read/write ordering: WRITE and READ never occur in the same cycle (one frame per cycle). A READ in the cycle after a WRITE to the same address returns the new data.
- rx_valid=0: no pointer or memory change; the tx handshake still proceeds.

Optional Feature:
- Macro: SPI_RAM_BURST_AUTOINC_EN.
- Defined: pointers post-increment after WRITE and READ, as described above.
- Undefined: pointers change only via WR_ADDR/RD_ADDR (and the out-of-range reset to 0). Repeated READ returns the same word; repeated WRITE overwrites the same word.

Decomposition:
- Package spi_ram_pkg:
  - opcode localparams OPC_WR_ADDR=0, OPC_WRITE=1, OPC_RD_ADDR=2, OPC_READ=3;
  - function addr_frames(ADDR_W, DATA_W) = ceil(ADDR_W/DATA_W).
- Sub-module spi_ram_array: DATA_W x MEM_DEPTH single-port array with synchronous write, registered read and an in-range guard.
- Pointer, handshake and error logic stay in the top module.

Test Plan (DATA_W=8, ADDR_W=10, MEM_DEPTH=1000, AUTOINC defined, tx_ready=1 unless stated):
- Address and write:
  - Stimulus: WR_ADDR 0x01, WR_ADDR 0x2C (wr_ptr=0x12C); WRITE 0xA1, 0xA2, 0xA3; then RD_ADDR 0x01, RD_ADDR 0x2C; READ x3.
  - Response: dout 0xA1, 0xA2, 0xA3 with tx_valid high in each of the three cycles; rd_ptr=0x12F afterwards.
- Wrap:
  - Stimulus: wr_ptr=999; WRITE 0x55, WRITE 0x66.
  - Response: mem[999]=0x55, mem[0]=0x66, addr_err=0.
- Out-of-range:
  - Stimulus: WR_ADDR 0x03, WR_ADDR 0xF0 (ptr=1008); WRITE 0x77.
  - Response: memory unchanged, addr_err=1 and sticky, wr_ptr=0.
- Backpressure:
  - Stimulus: tx_ready=0; READ of 0xA1; second READ.
  - Response: second READ gives rd_overrun pulse of 1 cycle; dout stays 0xA1; rd_ptr advances once only.
  - Stimulus: then tx_ready=1 with a READ in the same cycle.
  - Response: dout=next word, tx_valid stays 1.
- Reset mid-burst:
  - Stimulus: rst_n=0 for 1 cycle between READs while tx_valid=1.
  - Response: tx_valid=0, pointers=0, addr_err=0; mem[0x12C] still 0xA1.
- Macro undefined:
  - Stimulus: WRITE 0x11, WRITE 0x22; READ x2.
  - Response: both reads return 0x22 from the same address.

Source files
------------

// File: rtl/spi_ram_burst_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_pkg
//  Description : Shared opcodes and helpers for the SPI burst RAM controller.
//                Frame opcode lives in din[DATA_W+1:DATA_W].
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_ram_pkg;

    localparam logic [1:0] OPC_WR_ADDR = 2'd0;
    localparam logic [1:0] OPC_WRITE   = 2'd1;
    localparam logic [1:0] OPC_RD_ADDR = 2'd2;
    localparam logic [1:0] OPC_READ    = 2'd3;

    // Number of WR_ADDR/RD_ADDR frames needed to load a full pointer
    function automatic int addr_frames(input int addr_w, input int data_w);
        return (addr_w + data_w - 1) / data_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_ram_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_burst_ctrl_if
//  Description : Frame/readback bus between the SPI slave (master side) and
//                the burst RAM controller (slave side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface spi_ram_burst_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              rx_valid;
    logic [DATA_W+1:0] din;
    logic              tx_ready;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              rd_overrun;
    logic              addr_err;

    modport master (
        output rx_valid, din, tx_ready,
        input  dout, tx_valid, rd_overrun, addr_err
    );

    modport slave (
        input  rx_valid, din, tx_ready,
        output dout, tx_valid, rd_overrun, addr_err
    );
endinterface
`default_nettype wire

// File: rtl/spi_ram_burst_ctrl_array.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_array
//  Description : DATA_W x MEM_DEPTH single-port storage. Synchronous write,
//                registered read. Addresses >= MEM_DEPTH never write and
//                read back as zero. Storage itself is not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_array #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter int MEM_DEPTH = 1024
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              wr_en_i,
    input  wire logic [ADDR_W-1:0] wr_addr_i,
    input  wire logic [DATA_W-1:0] wr_data_i,
    input  wire logic              rd_en_i,
    input  wire logic [ADDR_W-1:0] rd_addr_i,
    output logic      [DATA_W-1:0] rd_data_o
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    logic              wr_in_range;
    logic              rd_in_range;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign wr_in_range = ({1'b0, wr_addr_i} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, rd_addr_i} < DEPTH_EXT);
    assign wr_idx      = wr_addr_i[IDX_W-1:0];
    assign rd_idx      = rd_addr_i[IDX_W-1:0];

    // Store a word; writes are blocked during reset and when out of range
    always_ff @(posedge clk) begin
        if (rst_n && wr_en_i && wr_in_range) begin
            mem_q[wr_idx] <= wr_data_i;
        end
    end

    // Capture the addressed word on a read; out-of-range reads return zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_in_range ? mem_q[rd_idx] : '0;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/spi_ram_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : spi_ram_burst_ctrl
//  Description : Command-decoding RAM behind an SPI slave. Independent write
//                and read pointers loaded MSB-first over several address
//                frames, tx_valid/tx_ready backpressure on read data,
//                one-cycle overrun pulse and sticky address-error flag.
//                Build option SPI_RAM_BURST_AUTOINC_EN: when defined the
//                pointers post-increment (wrapping at MEM_DEPTH) after each
//                WRITE / accepted READ; otherwise they hold.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_ram_burst_ctrl
    import spi_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter int MEM_DEPTH = 1024
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    spi_ram_burst_ctrl_if.slave   bus
);

`ifdef SPI_RAM_BURST_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              tx_valid_q, tx_valid_d;
    logic              rd_overrun_q, rd_overrun_d;
    logic              addr_err_q, addr_err_d;

    logic [1:0]        opc;
    logic [DATA_W-1:0] payload;
    logic              wr_en;
    logic              rd_accept;
    logic              wr_in_range;
    logic              rd_in_range;

    // New address bits enter at the bottom; the oldest bits fall off the top
    function automatic logic [ADDR_W-1:0] shift_in(input logic [ADDR_W-1:0] ptr,
                                                   input logic [DATA_W-1:0] pl);
        logic [ADDR_W+DATA_W-1:0] cat;
        cat = {ptr, pl};
        return cat[ADDR_W-1:0];
    endfunction

    // Wrap at the last real word, not at the pointer's binary range
    function automatic logic [ADDR_W-1:0] advance(input logic [ADDR_W-1:0] ptr);
        return (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
    endfunction

    assign opc         = bus.din[DATA_W+1:DATA_W];
    assign payload     = bus.din[DATA_W-1:0];
    assign wr_in_range = ({1'b0, wr_ptr_q} < DEPTH_EXT);
    assign rd_in_range = ({1'b0, rd_ptr_q} < DEPTH_EXT);
    assign wr_en       = bus.rx_valid && (opc == OPC_WRITE);
    // A READ may replace a word that is being handed off in the same cycle
    assign rd_accept   = bus.rx_valid && (opc == OPC_READ) &&
                         (!tx_valid_q || bus.tx_ready);

    // Decode one frame: pointer updates, handshake and error bookkeeping
    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_overrun_d = 1'b0;
        addr_err_d   = addr_err_q;

        if (rd_accept) begin
            tx_valid_d = 1'b1;
        end else if (bus.tx_ready) begin
            tx_valid_d = 1'b0;
        end else begin
            tx_valid_d = tx_valid_q;
        end

        if (bus.rx_valid) begin
            case (opc)
                OPC_WR_ADDR: wr_ptr_d = shift_in(wr_ptr_q, payload);
                OPC_WRITE: begin
                    if (!wr_in_range) begin
                        addr_err_d = 1'b1;
                        wr_ptr_d   = '0;
                    end else if (AUTOINC) begin
                        wr_ptr_d = advance(wr_ptr_q);
                    end
                end
                OPC_RD_ADDR: rd_ptr_d = shift_in(rd_ptr_q, payload);
                OPC_READ: begin
                    if (!rd_accept) begin
                        rd_overrun_d = 1'b1;
                    end else if (!rd_in_range) begin
                        addr_err_d = 1'b1;
                        rd_ptr_d   = '0;
                    end else if (AUTOINC) begin
                        rd_ptr_d = advance(rd_ptr_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // Control state registers; reset abandons any burst and pending word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            tx_valid_q   <= 1'b0;
            rd_overrun_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            tx_valid_q   <= tx_valid_d;
            rd_overrun_q <= rd_overrun_d;
            addr_err_q   <= addr_err_d;
        end
    end

    // dout is the array's read register, loaded at the accepting edge
    spi_ram_array #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (payload),
        .rd_en_i   (rd_accept),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (bus.dout)
    );

    assign bus.tx_valid   = tx_valid_q;
    assign bus.rd_overrun = rd_overrun_q;
    assign bus.addr_err   = addr_err_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_ram_burst_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_ram_burst_ctrl
//  Description : Self-checking bench for spi_ram_burst_ctrl
//                (DATA_W=8, ADDR_W=10, MEM_DEPTH=1000). Follows the
//                SPI_RAM_BURST_AUTOINC_EN setting of the build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_ram_burst_ctrl;
    import spi_ram_pkg::*;

    localparam int DW    = 8;
    localparam int AW    = 10;
    localparam int DEPTH = 1000;
`ifdef SPI_RAM_BURST_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_ram_burst_ctrl_if #(.DATA_W(DW)) bus ();

    spi_ram_burst_ctrl #(
        .DATA_W    (DW),
        .ADDR_W    (AW),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: plain integers and arrays
    int m_mem   [DEPTH];
    bit m_known [DEPTH];
    int m_wr, m_rd, m_dout;
    bit m_dk, m_txv, m_ovr, m_err;
    bit m_live = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply the frame rules to the reference state for the edge just taken
    task automatic model_update();
        bit       v, txr, acc;
        int       op, pl;
        if (!rst_n) begin
            m_wr = 0; m_rd = 0; m_dout = 0; m_dk = 1'b1;
            m_txv = 1'b0; m_ovr = 1'b0; m_err = 1'b0; m_live = 1'b1;
            return;
        end
        if (!m_live) return;
        v   = bus.rx_valid;
        op  = int'(bus.din[9:8]);
        pl  = int'(bus.din[7:0]);
        txr = bus.tx_ready;
        acc = v && (op == 3) && (!m_txv || txr);
        m_ovr = v && (op == 3) && !acc;
        if (acc)      m_txv = 1'b1;
        else if (txr) m_txv = 1'b0;
        if (v) begin
            case (op)
                0: m_wr = (m_wr * 256 + pl) % 1024;
                1: begin
                    if (m_wr >= DEPTH) begin
                        m_err = 1'b1; m_wr = 0;
                    end else begin
                        m_mem[m_wr] = pl; m_known[m_wr] = 1'b1;
                        if (AUTOINC) m_wr = (m_wr + 1) % DEPTH;
                    end
                end
                2: m_rd = (m_rd * 256 + pl) % 1024;
                default: begin
                    if (acc) begin
                        if (m_rd >= DEPTH) begin
                            m_dout = 0; m_dk = 1'b1; m_err = 1'b1; m_rd = 0;
                        end else begin
                            m_dout = m_mem[m_rd]; m_dk = m_known[m_rd];
                            if (AUTOINC) m_rd = (m_rd + 1) % DEPTH;
                        end
                    end
                end
            endcase
        end
    endtask

    // One clock: drive inputs, take the edge, update the model, settle
    task automatic step(input bit v, input bit [1:0] op, input bit [7:0] pl, input bit txr);
        bus.rx_valid = v;
        bus.din      = {op, pl};
        bus.tx_ready = txr;
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic set_addr(input bit [1:0] op, input int a);
        for (int i = addr_frames(AW, DW) - 1; i >= 0; i--) begin
            step(1'b1, op, 8'((a >> (8 * i)) & 'hFF), 1'b1);
        end
    endtask

    task automatic wr(input bit [7:0] pl);  step(1'b1, 2'd1, pl, 1'b1);   endtask
    task automatic rd(input bit txr);       step(1'b1, 2'd3, 8'h00, txr); endtask
    task automatic idle(input bit txr);     step(1'b0, 2'd0, 8'h00, txr); endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(1'b1);
        rst_n = 1'b1;
    endtask

    // Every-cycle comparison of the DUT against the reference state
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("tx_valid",   32'(bus.tx_valid),   32'(m_txv));
                check("rd_overrun", 32'(bus.rd_overrun), 32'(m_ovr));
                check("addr_err",   32'(bus.addr_err),   32'(m_err));
                if (m_dk) check("dout", 32'(bus.dout), 32'(m_dout));
            end
        end
    end

    initial begin
        bus.rx_valid = 1'b0;
        bus.din      = '0;
        bus.tx_ready = 1'b1;

        // Reset state
        do_reset();
        idle(1'b1);
        check("rst_dout",     32'(bus.dout),       32'h0);
        check("rst_tx_valid", 32'(bus.tx_valid),   32'h0);
        check("rst_addr_err", 32'(bus.addr_err),   32'h0);
        check("rst_overrun",  32'(bus.rd_overrun), 32'h0);

        // Address and burst write / burst read at 0x12C
        set_addr(2'd0, 'h12C);
        wr(8'hA1); wr(8'hA2); wr(8'hA3);
        set_addr(2'd2, 'h12C);
        rd(1'b1);
        check("burst_rd0", 32'(bus.dout), AUTOINC ? 32'hA1 : 32'hA3);
        check("burst_v0",  32'(bus.tx_valid), 32'h1);
        rd(1'b1);
        check("burst_rd1", 32'(bus.dout), AUTOINC ? 32'hA2 : 32'hA3);
        check("burst_v1",  32'(bus.tx_valid), 32'h1);
        rd(1'b1);
        check("burst_rd2", 32'(bus.dout), 32'hA3);
        check("burst_v2",  32'(bus.tx_valid), 32'h1);
        idle(1'b1);
        check("burst_drain", 32'(bus.tx_valid), 32'h0);

        // Wrap at MEM_DEPTH-1
        set_addr(2'd0, 999);
        wr(8'h55); wr(8'h66);
        check("wrap_err", 32'(bus.addr_err), 32'h0);
        set_addr(2'd2, 999);
        rd(1'b1);
        check("wrap_rd999", 32'(bus.dout), AUTOINC ? 32'h55 : 32'h66);
        rd(1'b1);
        check("wrap_rd_next", 32'(bus.dout), 32'h66);
        idle(1'b1);

        // Out-of-range write: flag, sticky, pointer back to 0
        set_addr(2'd0, 1008);
        wr(8'h77);
        check("oor_err", 32'(bus.addr_err), 32'h1);
        idle(1'b1); idle(1'b1); idle(1'b1);
        check("oor_sticky", 32'(bus.addr_err), 32'h1);
        wr(8'h78);
        set_addr(2'd2, 0);
        rd(1'b1);
        check("oor_ptr0", 32'(bus.dout), 32'h78);
        idle(1'b1);

        // Backpressure and overrun
        set_addr(2'd2, 'h12C);
        rd(1'b0);
        check("bp_first", 32'(bus.dout), AUTOINC ? 32'hA1 : 32'hA3);
        rd(1'b0);
        check("bp_overrun", 32'(bus.rd_overrun), 32'h1);
        check("bp_hold",    32'(bus.dout), AUTOINC ? 32'hA1 : 32'hA3);
        idle(1'b0);
        check("bp_pulse1", 32'(bus.rd_overrun), 32'h0);
        check("bp_valid",  32'(bus.tx_valid), 32'h1);
        rd(1'b1);
        check("bp_next",  32'(bus.dout), AUTOINC ? 32'hA2 : 32'hA3);
        check("bp_cont",  32'(bus.tx_valid), 32'h1);
        idle(1'b1);

        // Reset mid-burst with a pending word
        set_addr(2'd2, 'h12C);
        rd(1'b0);
        rst_n = 1'b0;
        idle(1'b0);
        rst_n = 1'b1;
        check("mid_rst_valid", 32'(bus.tx_valid), 32'h0);
        check("mid_rst_err",   32'(bus.addr_err), 32'h0);
        check("mid_rst_dout",  32'(bus.dout), 32'h0);
        rd(1'b1);
        check("mid_rst_rdptr0", 32'(bus.dout), 32'h78);
        wr(8'h5A);
        set_addr(2'd2, 0);
        rd(1'b1);
        check("mid_rst_wrptr0", 32'(bus.dout), 32'h5A);
        set_addr(2'd2, 'h12C);
        rd(1'b1);
        check("mid_rst_mem", 32'(bus.dout), AUTOINC ? 32'hA1 : 32'hA3);
        idle(1'b1);

        // Repeated access at one address
        set_addr(2'd0, 5);
        wr(8'h11); wr(8'h22);
        set_addr(2'd2, 5);
        rd(1'b1);
        check("rep_rd0", 32'(bus.dout), AUTOINC ? 32'h11 : 32'h22);
        rd(1'b1);
        check("rep_rd1", 32'(bus.dout), 32'h22);
        idle(1'b1);

        // Fill every word so random reads are fully predictable
        for (int a = 0; a < DEPTH; a++) begin
            set_addr(2'd0, a);
            wr(8'($urandom));
        end

        // Randomised frames, backpressure and occasional resets
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom),
                     $urandom_range(0, 1) == 1);
            end
        end
        idle(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
